// File: rtl/clk_sched_pkg.sv
// Shared types and constants for the clock-enable scheduler.
package clk_sched_pkg;

    localparam int unsigned DivWDefault = 8;
    localparam int unsigned TickCountW  = 16;

    typedef enum logic [1:0] {
        StHalt = 2'd0,
        StRun  = 2'd1,
        StStep = 2'd2
    } sched_state_e;

endpackage

// File: rtl/clk_en_scheduler_if.sv
// Control/status bundle between a console master and the clock-enable scheduler.
interface clk_en_scheduler_if #(
    parameter int unsigned DIV_W = clk_sched_pkg::DivWDefault
);
    import clk_sched_pkg::*;

    logic [DIV_W-1:0]      div_i;
    logic                  div_load_i;
    logic                  run_i;
    logic                  step_req_i;
    logic                  step_ack_o;
    logic                  tick_o;
    logic                  phase_o;
    logic                  running_o;
    logic [DIV_W-1:0]      div_active_o;
    logic [TickCountW-1:0] tick_count_o;

    modport master (
        output div_i, div_load_i, run_i, step_req_i,
        input  step_ack_o, tick_o, phase_o, running_o, div_active_o, tick_count_o
    );

    modport slave (
        input  div_i, div_load_i, run_i, step_req_i,
        output step_ack_o, tick_o, phase_o, running_o, div_active_o, tick_count_o
    );

endinterface

// File: rtl/clk_sched_period_ctr.sv
// Period counter: counts 0..d-1 while enabled, flags the wrap cycle, registers the phase.
module clk_sched_period_ctr #(
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en_i,
    input  logic [DIV_W-1:0] d_i,
    output logic [DIV_W-1:0] cnt_o,
    output logic             wrap_o,
    output logic             phase_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;
    logic             wrap;

    always_comb begin
        wrap  = en_i && (cnt_q == d_i - DIV_W'(1));
        cnt_d = '0;
        if (en_i && !wrap) begin
            cnt_d = cnt_q + DIV_W'(1);
        end
        // cnt_d == 0 covers halt, d == 1 and a divisor change at the boundary
        phase_d = (cnt_d == '0) || (cnt_d < (d_i >> 1));
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt_q   <= '0;
            phase_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign cnt_o   = cnt_q;
    assign wrap_o  = wrap;
    assign phase_o = phase_q;

endmodule

// File: rtl/clk_en_scheduler.sv
// Clock-enable scheduler: run/halt/step FSM with boundary-deferred divisor changes.
// Optional tick counter enabled by defining CLK_EN_SCHED_TICK_COUNT_EN.
module clk_en_scheduler
    import clk_sched_pkg::*;
#(
    parameter int unsigned DIV_W       = DivWDefault,
    parameter int unsigned DEFAULT_DIV = 4
) (
    input logic               clk_in,
    input logic               rst,
    clk_en_scheduler_if.slave bus
);

    sched_state_e     state_q, state_d;
    logic [DIV_W-1:0] pend_q, pend_d;
    logic             pend_valid_q, pend_valid_d;
    logic [DIV_W-1:0] div_active_q, div_active_d;
    logic             step_ack_q, step_ack_d;
    logic [DIV_W-1:0] eff_div;
    logic [DIV_W-1:0] cnt;
    logic             wrap;
    logic             phase;
    logic             apply;

    assign eff_div = (div_active_q == '0) ? DIV_W'(1) : div_active_q;

    clk_sched_period_ctr #(
        .DIV_W (DIV_W)
    ) u_period_ctr (
        .clk_in  (clk_in),
        .rst     (rst),
        .en_i    (state_q != StHalt),
        .d_i     (eff_div),
        .cnt_o   (cnt),
        .wrap_o  (wrap),
        .phase_o (phase)
    );

    always_comb begin
        state_d    = state_q;
        step_ack_d = 1'b0;
        unique case (state_q)
            StHalt: begin
                if (bus.step_req_i) begin
                    state_d = StStep;
                end else if (bus.run_i) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (wrap && !bus.run_i) begin
                    state_d = StHalt;
                end
            end
            StStep: begin
                if (wrap) begin
                    state_d    = bus.run_i ? StRun : StHalt;
                    step_ack_d = 1'b1;
                end
            end
            default: state_d = StHalt;
        endcase
    end

    // A load coinciding with a boundary still lets the older pending value apply first
    always_comb begin
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        div_active_d = div_active_q;
        apply        = pend_valid_q && (wrap || (state_q == StHalt));
        if (apply) begin
            div_active_d = pend_q;
            pend_valid_d = 1'b0;
        end
        if (bus.div_load_i) begin
            pend_d       = bus.div_i;
            pend_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q      <= StHalt;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            div_active_q <= DIV_W'(DEFAULT_DIV);
            step_ack_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            div_active_q <= div_active_d;
            step_ack_q   <= step_ack_d;
        end
    end

`ifdef CLK_EN_SCHED_TICK_COUNT_EN
    logic [TickCountW-1:0] tick_cnt_q, tick_cnt_d;

    always_comb begin
        tick_cnt_d = tick_cnt_q + TickCountW'(wrap);
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

    assign bus.tick_count_o = tick_cnt_q;
`else
    assign bus.tick_count_o = '0;
`endif

    assign bus.tick_o       = wrap;
    assign bus.phase_o      = phase;
    assign bus.running_o    = (state_q != StHalt);
    assign bus.step_ack_o   = step_ack_q;
    assign bus.div_active_o = div_active_q;

    halt_holds_cnt : assert property (@(posedge clk_in) disable iff (rst)
        (state_q == StHalt) |-> (cnt == '0));

endmodule

// File: tb/tb_clk_en_scheduler.sv
// Directed bench for clk_en_scheduler: vector table plus hand-written step/halt/reset sequences.
module tb_clk_en_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    clk_en_scheduler_if #(.DIV_W(8)) bus ();

    clk_en_scheduler #(
        .DIV_W       (8),
        .DEFAULT_DIV (4)
    ) dut (
        .clk_in (clk),
        .rst    (rst),
        .bus    (bus)
    );

    typedef struct {
        logic       run;
        logic       step;
        logic       load;
        logic [7:0] div;
        logic       tick;
        logic       phase;
        logic       running;
        logic       ack;
        logic [7:0] dact;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clk_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.run_i      = 1'b0;
        bus.step_req_i = 1'b0;
        bus.div_load_i = 1'b0;
        bus.div_i      = '0;
    endtask

    // Load a divisor while halted and let it apply
    task automatic load_halted(input logic [7:0] dv);
        bus.div_i      = dv;
        bus.div_load_i = 1'b1;
        clk_step();
        bus.div_load_i = 1'b0;
        clk_step();
        chk("halt_load_div_active", bus.div_active_o, dv);
    endtask

    task automatic run_single(input logic [7:0] dv);
        load_halted(dv);
        bus.run_i = 1'b1;
        clk_step();
        for (int k = 0; k < 4; k++) begin
            chk("d1_tick", bus.tick_o, 1);
            chk("d1_phase", bus.phase_o, 1);
            clk_step();
        end
        bus.run_i = 1'b0;
        clk_step();
        chk("d1_halted", bus.running_o, 0);
        chk("d1_halted_tick", bus.tick_o, 0);
    endtask

    initial begin
        // Free-run at d=4, load 6 mid-period, halt at the wrap of the first 6-period
        vecs[0]  = '{1, 0, 0, 8'd0, 0, 1, 0, 0, 8'd4};
        vecs[1]  = '{1, 0, 0, 8'd0, 0, 1, 1, 0, 8'd4};
        vecs[2]  = '{1, 0, 0, 8'd0, 0, 1, 1, 0, 8'd4};
        vecs[3]  = '{1, 0, 0, 8'd0, 0, 0, 1, 0, 8'd4};
        vecs[4]  = '{1, 0, 0, 8'd0, 1, 0, 1, 0, 8'd4};
        vecs[5]  = '{1, 0, 0, 8'd0, 0, 1, 1, 0, 8'd4};
        vecs[6]  = '{1, 0, 1, 8'd6, 0, 1, 1, 0, 8'd4};
        vecs[7]  = '{1, 0, 0, 8'd0, 0, 0, 1, 0, 8'd4};
        vecs[8]  = '{1, 0, 0, 8'd0, 1, 0, 1, 0, 8'd4};
        vecs[9]  = '{1, 0, 0, 8'd0, 0, 1, 1, 0, 8'd6};
        vecs[10] = '{1, 0, 0, 8'd0, 0, 1, 1, 0, 8'd6};
        vecs[11] = '{1, 0, 0, 8'd0, 0, 1, 1, 0, 8'd6};
        vecs[12] = '{1, 0, 0, 8'd0, 0, 0, 1, 0, 8'd6};
        vecs[13] = '{1, 0, 0, 8'd0, 0, 0, 1, 0, 8'd6};
        vecs[14] = '{0, 0, 0, 8'd0, 1, 0, 1, 0, 8'd6};
        vecs[15] = '{0, 0, 0, 8'd0, 0, 1, 0, 0, 8'd6};
        vecs[16] = '{0, 0, 0, 8'd0, 0, 1, 0, 0, 8'd6};

        idle_inputs();
        rst = 1'b1;
        clk_step();
        clk_step();
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            bus.run_i      = vecs[i].run;
            bus.step_req_i = vecs[i].step;
            bus.div_load_i = vecs[i].load;
            bus.div_i      = vecs[i].div;
            chk($sformatf("vec%0d_tick", i), bus.tick_o, vecs[i].tick);
            chk($sformatf("vec%0d_phase", i), bus.phase_o, vecs[i].phase);
            chk($sformatf("vec%0d_running", i), bus.running_o, vecs[i].running);
            chk($sformatf("vec%0d_ack", i), bus.step_ack_o, vecs[i].ack);
            chk($sformatf("vec%0d_div_active", i), bus.div_active_o, vecs[i].dact);
            clk_step();
        end
        idle_inputs();

        // Single step at d=3 while halted
        load_halted(8'd3);
        bus.step_req_i = 1'b1;
        chk("step_pre_running", bus.running_o, 0);
        clk_step();
        bus.step_req_i = 1'b0;
        chk("step_c1_running", bus.running_o, 1);
        chk("step_c1_tick", bus.tick_o, 0);
        clk_step();
        chk("step_c2_tick", bus.tick_o, 0);
        chk("step_c2_phase", bus.phase_o, 0);
        clk_step();
        chk("step_c3_tick", bus.tick_o, 1);
        chk("step_c3_ack", bus.step_ack_o, 0);
        clk_step();
        chk("step_c4_ack", bus.step_ack_o, 1);
        chk("step_c4_running", bus.running_o, 0);
        chk("step_c4_tick", bus.tick_o, 0);
        for (int k = 0; k < 4; k++) begin
            clk_step();
            chk("step_after_tick", bus.tick_o, 0);
            chk("step_after_ack", bus.step_ack_o, 0);
            chk("step_after_running", bus.running_o, 0);
        end

        // Step wins over run; ends in RUN; step while running is ignored
        bus.run_i      = 1'b1;
        bus.step_req_i = 1'b1;
        clk_step();
        bus.step_req_i = 1'b0;
        clk_step();
        clk_step();
        chk("steprun_tick", bus.tick_o, 1);
        clk_step();
        chk("steprun_ack", bus.step_ack_o, 1);
        chk("steprun_running", bus.running_o, 1);
        bus.step_req_i = 1'b1;
        clk_step();
        bus.step_req_i = 1'b0;
        chk("run_step_ignored_ack1", bus.step_ack_o, 0);
        clk_step();
        chk("run_step_ignored_ack2", bus.step_ack_o, 0);
        chk("run_step_tick", bus.tick_o, 1);
        bus.run_i = 1'b0;
        clk_step();
        chk("run_step_halted", bus.running_o, 0);
        chk("run_step_ack3", bus.step_ack_o, 0);

        // Drop run at cnt=0 with d=5: the period still completes
        load_halted(8'd5);
        bus.run_i = 1'b1;
        clk_step();
        bus.run_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("drop_no_tick", bus.tick_o, 0);
            chk("drop_running", bus.running_o, 1);
            clk_step();
        end
        chk("drop_tick", bus.tick_o, 1);
        chk("drop_phase", bus.phase_o, 0);
        clk_step();
        for (int k = 0; k < 4; k++) begin
            chk("drop_halt_running", bus.running_o, 0);
            chk("drop_halt_tick", bus.tick_o, 0);
            chk("drop_halt_phase", bus.phase_o, 1);
            clk_step();
        end

        // Divisor 0 behaves as 1, then divisor 1
        run_single(8'd0);
        run_single(8'd1);

        // Reset mid-period drops the pending divisor
        load_halted(8'd3);
        bus.run_i = 1'b1;
        clk_step();
        clk_step();
        bus.div_i      = 8'd7;
        bus.div_load_i = 1'b1;
        clk_step();
        bus.div_load_i = 1'b0;
        rst = 1'b1;
        clk_step();
        chk("rst_tick", bus.tick_o, 0);
        chk("rst_phase", bus.phase_o, 1);
        chk("rst_running", bus.running_o, 0);
        chk("rst_ack", bus.step_ack_o, 0);
        chk("rst_div_active", bus.div_active_o, 4);
        chk("rst_tick_count", bus.tick_count_o, 0);
        rst = 1'b0;
        bus.run_i = 1'b0;
        clk_step();
        clk_step();
        clk_step();
        chk("rst_pend_dropped", bus.div_active_o, 4);

        // Reset during a step: no ack afterwards
        bus.step_req_i = 1'b1;
        clk_step();
        bus.step_req_i = 1'b0;
        clk_step();
        rst = 1'b1;
        clk_step();
        rst = 1'b0;
        chk("rst_step_ack0", bus.step_ack_o, 0);
        for (int k = 0; k < 5; k++) begin
            clk_step();
            chk("rst_step_ack", bus.step_ack_o, 0);
            chk("rst_step_running", bus.running_o, 0);
        end

`ifdef CLK_EN_SCHED_TICK_COUNT_EN
        load_halted(8'd1);
        chk("cnt_start", bus.tick_count_o, 0);
        bus.run_i = 1'b1;
        clk_step();
        chk("cnt_first_run_cycle", bus.tick_count_o, 0);
        repeat (65537) clk_step();
        chk("cnt_wrap", bus.tick_count_o, 1);
        bus.run_i = 1'b0;
        rst = 1'b1;
        clk_step();
        rst = 1'b0;
        chk("cnt_rst", bus.tick_count_o, 0);
        chk("cnt_rst_running", bus.running_o, 0);
`else
        load_halted(8'd1);
        bus.run_i = 1'b1;
        repeat (10) clk_step();
        chk("cnt_tied_zero", bus.tick_count_o, 0);
        bus.run_i = 1'b0;
        clk_step();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_en_scheduler.md
Name: clk_en_scheduler

Overview:
- Controller for the system clock-division resource. Runtime-programmable divisor in place of a fixed compile-time ratio.
- Generates a one-cycle clock-enable strobe (tick_o) and a square phase signal from a single clk_in.
- Sequences run/halt/single-step for the debug console path.
- Divisor changes are deferred to a period boundary so enabled logic never sees a short or long glitch period.

Parameters:
- DIV_W, 8, width of divisor and period counter.
- DEFAULT_DIV, 4, divisor loaded at reset; must be in 1..2^DIV_W-1.

Ports:
- clk_in  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- div_i  input  DIV_W  requested divisor.
- div_load_i  input  1  one-cycle strobe; captures div_i as the pending divisor.
- run_i  input  1  level; 1 = free-run ticks, 0 = halt at next period boundary.
- step_req_i  input  1  one-cycle strobe; requests exactly one period while halted.
- step_ack_o  output  1  one-cycle pulse when a requested step completes.
- tick_o  output  1  one-cycle enable strobe, once per period.
- phase_o  output  1  divided square wave.
- running_o  output  1  state != HALT.
- div_active_o  output  DIV_W  divisor currently in effect.
- tick_count_o  output  16  tick counter (see Optional Feature).

Behaviour:
- Reset values:
  - state = HALT, cnt = 0, div_active = DEFAULT_DIV, pend_valid = 0.
  - step_ack_o = 0, tick_o = 0, phase_o = 1, running_o = 0.
- States and transitions:
  - HALT → STEP on step_req_i. Step has priority over run_i in the same cycle.
  - HALT → RUN on run_i = 1 with no step_req_i.
  - RUN → HALT only at wrap, when run_i = 0 in the wrap cycle. The current period always completes, with its tick.
  - STEP → (run_i ? RUN : HALT) at wrap. step_ack_o pulses the cycle after the wrap.
- Divisor:
  - Effective divisor d = max(div_active, 1). A divisor of 0 is treated as 1.
- Counter:
  - Counts 0..d-1 while in RUN or STEP. Wrap cycle is cnt == d-1; cnt goes to 0 after it.
  - Held at 0 in HALT.
- tick_o:
  - Combinational: (state != HALT) && cnt == d-1.
  - Entering RUN at cycle n+1 (run_i sampled at n) gives the first tick at cycle n+d, then one tick every d cycles.
  - d = 1 gives a tick every cycle.
- phase_o:
  - Registered; equals (cnt < d/2), using integer floor.
  - Forced 1 when d == 1 or in HALT.
- Pending divisor:
  - div_load_i sets pend = div_i and pend_valid = 1. A later load before it applies overwrites it.
  - Applied to div_active at wrap, or on the next cycle if the state is HALT.
  - If div_load_i and a wrap coincide, the new value waits for the next boundary (HALT or next wrap).
- Ignored inputs:
  - step_req_i in RUN or STEP is ignored and produces no ack.
  - A second step_req_i in the ack cycle is accepted only if the state is HALT.
- rst mid-period: restores the reset values, drops the pending divisor, no ack.
- div_active_o updates the cycle after the divisor is applied.

Optional Feature:
- Macro: CLK_EN_SCHED_TICK_COUNT_EN.
- Defined:
  - tick_count_o is a 16-bit counter of tick_o, cleared by rst, wraps 0xFFFF→0.
- Undefined:
  - No counter logic; tick_count_o tied to 0.

Decomposition:
- Package clk_sched_pkg:
  - State encoding HALT=2'd0, RUN=2'd1, STEP=2'd2.
  - Default DIV_W.
  - Width constant for tick_count_o (16).
- One natural sub-module, clk_sched_period_ctr.
  - Inputs: en, d; outputs: cnt, wrap, phase.
  - Top level holds the FSM, pending-divisor logic and step handshake.

Test Plan:
- Reset, then run_i = 1 at cycle 0 with DEFAULT_DIV = 4 → first tick_o at cycle 4, then at 8, 12, …; phase_o = 1,1,0,0 per period.
- While RUN at d = 4, div_load_i with div_i = 6 at cnt = 1 → tick_o at the current wrap, then at +6 cycles; div_active_o = 6 one cycle after that wrap.
- HALT, step_req_i at cycle 10 with d = 3 → exactly one tick_o at cycle 13; step_ack_o at cycle 14; running_o drops at 14; no further ticks.
- RUN, run_i dropped at cnt = 0 with d = 5 → that period's tick still fires at cnt = 4, then HALT, cnt held at 0.
- div_i = 0 and div_i = 1 loaded while halted, then run → tick_o every cycle, phase_o constant 1.
- With CLK_EN_SCHED_TICK_COUNT_EN, d = 1, run 65537 cycles → tick_count_o wraps to 1; rst mid-run → all outputs at reset values on the next cycle.
